// File: rtl/mini_cpu_pkg.sv
// Shared opcodes, FSM encoding and instruction field layout for mini_cpu_ctrl
// and datapath_core.
package mini_cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Low bit of each field: op 4b, rd/rs1/rs2 2b, imm 8b (overlaps rs2).
    localparam int IR_OP_LSB  = 12;
    localparam int IR_RD_LSB  = 10;
    localparam int IR_RS1_LSB = 8;
    localparam int IR_RS2_LSB = 6;
    localparam int IR_IMM_LSB = 0;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_LDI);
    endfunction

endpackage

// File: rtl/datapath_core.sv
// Combinational ALU/shifter with Z/N/C/V flags. For SUB, Carry is the borrow
// out of A - B; C and V are 0 for logic, shift, SLT and unknown opcodes.
module datapath_core
    import mini_cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OpCode,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Neg,
    output logic             Carry,
    output logic             Overflow
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_slt;

    assign w_sum   = {1'b0, A} + {1'b0, B};
    assign w_diff  = {1'b0, A} - {1'b0, B};
    assign w_shamt = B[SHW-1:0];
    assign w_slt   = ($signed(A) < $signed(B));

    always_comb begin
        Result   = '0;
        Carry    = 1'b0;
        Overflow = 1'b0;
        case (OpCode)
            OP_ADD: begin
                Result   = w_sum[WIDTH-1:0];
                Carry    = w_sum[WIDTH];
                Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                Result   = w_diff[WIDTH-1:0];
                Carry    = w_diff[WIDTH];
                Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  Result = A & B;
            OP_OR:   Result = A | B;
            OP_XOR:  Result = A ^ B;
            OP_SLT:  Result[0] = w_slt;
            OP_SLL:  Result = A << w_shamt;
            OP_SRL:  Result = A >> w_shamt;
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);
    assign Neg  = Result[WIDTH-1];

endmodule

// File: rtl/mini_cpu_regfile.sv
// 4 x WIDTH register file: synchronous write and clear, three combinational
// read ports (two operands plus debug).
module mini_cpu_regfile #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [1:0]       i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [1:0]       i_raddr_a,
    input  logic [1:0]       i_raddr_b,
    input  logic [1:0]       i_dbg_addr,
    output logic [WIDTH-1:0] o_rdata_a,
    output logic [WIDTH-1:0] o_rdata_b,
    output logic [WIDTH-1:0] o_dbg_data
);

    logic [WIDTH-1:0] r_mem [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_rdata_b  = r_mem[i_raddr_b];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/mini_cpu_ctrl.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) around datapath_core and a 4-entry
// register file. MINI_CPU_RETIRE_CNT_EN enables the retired-instruction counter.
module mini_cpu_ctrl
    import mini_cpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [15:0]      retired,
    output state_t           dbg_state
);

    // Handshake: an instruction transfers on a rising edge where
    // instr_valid && instr_ready; the source holds instr stable until then.

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_ir;
    logic [WIDTH-1:0] r_opa, r_opb;
    logic [WIDTH-1:0] r_pend_res;
    logic             r_pend_z, r_pend_n, r_pend_c, r_pend_v;
    logic [WIDTH-1:0] r_result;
    logic             r_z, r_n, r_c, r_v;

    logic [3:0]       w_op;
    logic [1:0]       w_rd, w_rs1, w_rs2;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_rdata_a, w_rdata_b;
    logic [WIDTH-1:0] w_dp_res;
    logic             w_dp_z, w_dp_n, w_dp_c, w_dp_v;
    logic             w_in_wb, w_done, w_err;

    assign w_op  = r_ir[IR_OP_LSB +: 4];
    assign w_rd  = r_ir[IR_RD_LSB +: 2];
    assign w_rs1 = r_ir[IR_RS1_LSB +: 2];
    assign w_rs2 = r_ir[IR_RS2_LSB +: 2];
    assign w_imm = WIDTH'(r_ir[IR_IMM_LSB +: 8]);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (instr_valid) w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign instr_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;

    // Reset in the WB cycle suppresses the pulse as well as the write.
    assign w_in_wb = (r_state == S_WB) && !rst;
    assign w_done  = w_in_wb && op_legal(w_op);
    assign w_err   = w_in_wb && !op_legal(w_op);
    assign done    = w_done;
    assign err     = w_err;

    datapath_core #(.WIDTH(WIDTH)) u_dp (
        .A        (r_opa),
        .B        (r_opb),
        .OpCode   (w_op),
        .Result   (w_dp_res),
        .Zero     (w_dp_z),
        .Neg      (w_dp_n),
        .Carry    (w_dp_c),
        .Overflow (w_dp_v)
    );

    mini_cpu_regfile #(.WIDTH(WIDTH)) u_rf (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_done),
        .i_waddr    (w_rd),
        .i_wdata    (r_pend_res),
        .i_raddr_a  (w_rs1),
        .i_raddr_b  (w_rs2),
        .i_dbg_addr (dbg_addr),
        .o_rdata_a  (w_rdata_a),
        .o_rdata_b  (w_rdata_b),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir       <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_pend_res <= '0;
            r_pend_z   <= 1'b0;
            r_pend_n   <= 1'b0;
            r_pend_c   <= 1'b0;
            r_pend_v   <= 1'b0;
            r_result   <= '0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_c        <= 1'b0;
            r_v        <= 1'b0;
        end else begin
            if (r_state == S_IDLE && instr_valid) r_ir <= instr;
            if (r_state == S_READ) begin
                r_opa <= w_rdata_a;
                r_opb <= w_rdata_b;
            end
            if (r_state == S_EXEC) begin
                if (w_op == OP_LDI) begin
                    r_pend_res <= w_imm;
                    r_pend_z   <= (w_imm == '0);
                    r_pend_n   <= w_imm[WIDTH-1];
                    r_pend_c   <= 1'b0;
                    r_pend_v   <= 1'b0;
                end else begin
                    r_pend_res <= w_dp_res;
                    r_pend_z   <= w_dp_z;
                    r_pend_n   <= w_dp_n;
                    r_pend_c   <= w_dp_c;
                    r_pend_v   <= w_dp_v;
                end
            end
            if (w_done) begin
                r_result <= r_pend_res;
                r_z      <= r_pend_z;
                r_n      <= r_pend_n;
                r_c      <= r_pend_c;
                r_v      <= r_pend_v;
            end
        end
    end

    assign result = r_result;
    assign flag_z = r_z;
    assign flag_n = r_n;
    assign flag_c = r_c;
    assign flag_v = r_v;

`ifdef MINI_CPU_RETIRE_CNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge clk) begin
        if (rst)         r_retired <= '0;
        else if (w_done) r_retired <= r_retired + 16'd1;
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_mini_cpu_ctrl.sv
// Self-checking bench for mini_cpu_ctrl (WIDTH=8): scoreboard of expected
// writeback results plus directed latency, handshake and reset checks.
module tb_mini_cpu_ctrl;
    import mini_cpu_pkg::*;

    localparam int W = 8;
`ifdef MINI_CPU_RETIRE_CNT_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [15:0]  instr = '0;
    logic         busy, done, err;
    logic [W-1:0] result;
    logic         flag_z, flag_n, flag_c, flag_v;
    logic [1:0]   dbg_addr = '0;
    logic [W-1:0] dbg_data;
    logic [15:0]  retired;
    state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Entry: {err, z, n, c, v, result}
    logic [12:0]  exp_q[$];
    logic [W-1:0] mrf [4];
    logic [12:0]  mstate;
    int           mret;

    mini_cpu_ctrl #(.WIDTH(W), .NREGS(4)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .busy(busy), .done(done), .err(err), .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retired(retired),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [7:0] imm,
                                          input logic [12:0] prev);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            4'h0: begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W];
                        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'h1: begin t = {1'b0, a} - {1'b0, b}; r = t[W-1:0]; c = t[W];
                        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            4'h6: r = a << b[2:0];
            4'h7: r = a >> b[2:0];
            4'h8: r = imm;
            default: return {1'b1, prev[11:0]};
        endcase
        return {1'b0, (r == '0), r[W-1], c, v, r};
    endfunction

    // Builds the instruction word, pushes its expected outcome and advances the model.
    task automatic prep(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] imm,
                        output logic [15:0] ins, output logic [W-1:0] old);
        logic [12:0] e;
        ins = {op, rd, rs1, rs2, 6'b0};
        if (op == OP_LDI) ins[7:0] = imm;
        old = mrf[rd];
        e = model(op, mrf[rs1], mrf[rs2], imm, mstate);
        exp_q.push_back(e);
        mstate = {1'b0, e[11:0]};
        if (!e[12]) begin
            mrf[rd] = e[W-1:0];
            mret++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm);
        logic [15:0]  ins;
        logic [W-1:0] old;
        wait_ready();
        prep(op, rd, rs1, rs2, imm, ins, old);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        dbg_addr = rd;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("wb_pulse", {30'd0, done, err}, op_legal(op) ? 32'd2 : 32'd1);
        check("dbg_prewrite", dbg_data, old);
        @(posedge clk);
        #1 check("rf_after_wb", dbg_data, mrf[rd]);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) mrf[i] = '0;
        mstate = '0;
        mret = 0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1 check({tag, "_rf"}, dbg_data, 32'd0);
        end
        check({tag, "_res_flags"}, {flag_z, flag_n, flag_c, flag_v, result}, 32'd0);
        check({tag, "_retired"}, retired, 32'd0);
        check({tag, "_state"}, dbg_state, S_IDLE);
        check({tag, "_done_err"}, {done, err}, 32'd0);
    endtask

    // Result and flags settle on the edge that ends the WB cycle.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            logic e_bit;
            logic [12:0] e;
            e_bit = err;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_writeback", {e_bit, flag_z, flag_n, flag_c, flag_v, result}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]  ins;
        logic [W-1:0] old;
        int           n_acc;

        reset_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        check("reset_ready", {busy, instr_ready}, 32'd1);

        // Test 1: 0x7F + 0x01 overflows into the sign bit
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h7F);
        issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h01);
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00);
        check("t1_add_result", result, 32'h80);
        check("t1_add_zncv", {flag_z, flag_n, flag_c, flag_v}, 32'b0101);
        check("t1_retired", retired, RET_EN ? 32'd3 : 32'd0);

        // Test 2
        issue(OP_SUB, 2'd0, 2'd1, 2'd1, 8'h00);
        check("t2_sub_zncv", {flag_z, flag_n, flag_c, flag_v, result}, 32'b1000_0000_0000);

        // Test 3: shifts and SLT
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h01);
        issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h03);
        issue(OP_SLL, 2'd3, 2'd1, 2'd2, 8'h00);
        check("t3_sll", result, 32'h08);
        issue(OP_SRL, 2'd3, 2'd3, 2'd2, 8'h00);
        check("t3_srl", result, 32'h01);
        issue(OP_SLT, 2'd3, 2'd1, 2'd2, 8'h00);
        check("t3_slt", result, 32'h01);

        // Random mix of legal and illegal ops over all operand registers
        for (int i = 0; i < 12; i++) begin
            issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end

        // Test 4: illegal op leaves r1 and flags alone
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h55);
        issue(4'hF, 2'd1, 2'd2, 2'd3, 8'h00);
        dbg_addr = 2'd1;
        #1 check("t4_r1_kept", dbg_data, 32'h55);
        check("t4_flags_kept", {flag_z, flag_n, flag_c, flag_v, result}, 32'h055);

        // Test 5: valid held high across three back-to-back instructions
        n_acc = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            check("t5_ready_pattern", {31'd0, instr_ready}, (cyc % 4 == 0) ? 32'd1 : 32'd0);
            if (instr_ready && n_acc < 3) begin
                case (n_acc)
                    0:       prep(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h10, ins, old);
                    1:       prep(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h22, ins, old);
                    default: prep(OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00, ins, old);
                endcase
                instr = ins;
                instr_valid = 1'b1;
                n_acc++;
            end else if (n_acc == 3 && !instr_ready) begin
                instr_valid = 1'b0;
            end
        end
        check("t5_accepts", n_acc, 32'd3);
        wait_ready();
        dbg_addr = 2'd2;
        #1 check("t5_add_r2", dbg_data, 32'h32);

        // Test 6: reset during EXEC aborts the instruction
        instr = {OP_ADD, 2'd2, 2'd1, 2'd1, 6'b0};
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #1 check("t6_in_exec", dbg_state, S_EXEC);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        reset_model();
        @(negedge clk);
        check_all_zero("t6");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_pulse", {done, err}, 32'd0);
        end

        repeat (4) @(posedge clk);
        check("sb_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
